mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the RV32I pipeline, directly downstream of the execute-stage ALU. Consumes the ALU result (effective address or arithmetic result) plus store data and register-writeback tags, and runs load/store transactions on the data-memory bus via a request/acknowledge handshake. Delivers a registered writeback packet to the writeback stage. Loads are sign- or zero-extended and stores get byte lanes. Back-pressures execute through `in_ready` while a bus transaction is outstanding.

## Interface
- `DATA_LEN`, 32, datapath and bus width
- `ADDR_LEN`, 5, register-file address width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  execute packet present
- `in_ready`  out  1  stage accepts a packet this cycle; high exactly when state is IDLE
- `in_alu_out`  in  DATA_LEN  ALU result; effective address for memory ops
- `in_rs2_data`  in  DATA_LEN  store data
- `in_funct3`  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `in_mem_ren` / `in_mem_wen`  in  1 each  load / store; `wen` wins if both are set
- `in_rd_addr`  in  ADDR_LEN;  `in_rd_wen`  in  1  writeback tag
- `dmem_req`  out  1;  `dmem_we`  out  1;  `dmem_addr`  out  DATA_LEN (bits [1:0] = 0)
- `dmem_wdata`  out  DATA_LEN;  `dmem_be`  out  4;  `dmem_ack`  in  1;  `dmem_rdata`  in  DATA_LEN
- `out_valid`  out  1  one-cycle writeback pulse
- `out_rd_addr`  out  ADDR_LEN;  `out_rd_wen`  out  1;  `out_wb_data`  out  DATA_LEN
- `out_exc`  out  1;  `out_exc_addr`  out  DATA_LEN  misaligned-access report

## Operation
- States: IDLE and BUSY.
- Handshake fires when `in_valid && in_ready`.
- Non-memory packet accepted:
  - stay IDLE
  - next cycle `out_valid`=1, `out_wb_data`=`in_alu_out`, tags copied
- Memory packet accepted:
  - register address, funct3, store data and tags; go BUSY
  - in BUSY, `dmem_req`=1 and all `dmem_*` outputs are held stable until the `dmem_ack` cycle
  - on ack: capture `dmem_rdata`, return to IDLE
- Store lanes use `a`=`addr[1:0]`:
  - SB: `be`=0001<<a, `wdata`={4{rs2[7:0]}}
  - SH: `be`=0011<<{a[1],0}, `wdata`={2{rs2[15:0]}}
  - SW: `be`=1111, `wdata`=rs2
- Load extraction:
  - byte lane `a`; halfword lane `a[1]`
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word
  - `be`=1111 and `dmem_we`=0 for loads
- Store completion: `out_valid`=1 with `out_rd_wen`=0.
- `dmem_ack` while IDLE is ignored.
- Reset value of every output is 0, except `in_ready`=1 (IDLE).
- Reset mid-BUSY: `dmem_req` drops asynchronously; the transaction is abandoned with no `out_valid`; a later stray ack is ignored.

## Timing
- Non-memory latency: 1 cycle from acceptance to `out_valid`.
- Memory:
  - `dmem_req` rises the cycle after acceptance
  - ack is allowed in that first BUSY cycle
  - `out_valid` occurs the cycle after ack, so minimum latency is 2 cycles
- In the `out_valid` cycle the stage is already IDLE, so back-to-back acceptance is permitted.
- `out_*` outputs are registered and hold their value when `out_valid`=0; only `out_valid` pulses.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - misaligned cases are LH/LHU/SH with `addr[0]`=1, and LW/SW with `addr[1:0]`≠0
  - these issue no bus request and stay IDLE
  - next cycle: `out_valid`=1, `out_exc`=1, `out_exc_addr`=address, `out_rd_wen`=0
- Not defined:
  - low address bits beyond the access width are ignored (H uses `a[1]`, W uses lane 0)
  - `out_exc` and `out_exc_addr` are tied to 0

## Test plan
- ALU pass-through: `in_alu_out`=0x1234, rd=5, wen=1 → next cycle `out_valid`=1, `out_wb_data`=0x1234, `out_rd_addr`=5, no `dmem_req`.
- LB sign extension: addr 0x103, `dmem_rdata`=0x80FFFFFF, ack on 3rd BUSY cycle → `dmem_addr`=0x100, `out_wb_data`=0xFFFFFF80 one cycle after ack; LBU on the same data gives 0x80.
- SH upper half: addr 0x202, rs2=0xDEADBEEF → `dmem_we`=1, `be`=1100, `wdata`=0xBEEFBEEF, `out_rd_wen`=0; `in_ready`=0 until ack.
- Zero-wait ack plus back-to-back: ack in first BUSY cycle → `out_valid` next cycle; a new packet accepted that same cycle.
- Async reset while BUSY → `dmem_req`=0 immediately; a stray ack after reset produces no `out_valid`.
- With `MISALIGN_TRAP_EN`, LW addr 0x301 → no `dmem_req`, `out_exc`=1, `out_exc_addr`=0x301; without it, `dmem_addr`=0x300, `be`=1111.

Source files
------------

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: load/store over a req/ack data bus, registered writeback.
// Optional MISALIGN_TRAP_EN reports misaligned H/W accesses instead of issuing them.
module mem_access_stage #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_alu_out,
  input  logic [DATA_LEN-1:0] in_rs2_data,
  input  logic [2:0]          in_funct3,
  input  logic                in_mem_ren,
  input  logic                in_mem_wen,
  input  logic [ADDR_LEN-1:0] in_rd_addr,
  input  logic                in_rd_wen,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [DATA_LEN-1:0] dmem_addr,
  output logic [DATA_LEN-1:0] dmem_wdata,
  output logic [3:0]          dmem_be,
  input  logic                dmem_ack,
  input  logic [DATA_LEN-1:0] dmem_rdata,
  output logic                out_valid,
  output logic [ADDR_LEN-1:0] out_rd_addr,
  output logic                out_rd_wen,
  output logic [DATA_LEN-1:0] out_wb_data,
  output logic                out_exc,
  output logic [DATA_LEN-1:0] out_exc_addr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [DATA_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] sdata_q;
  logic [2:0]          f3_q;
  logic                we_q;
  logic [ADDR_LEN-1:0] rd_q;
  logic                rdwen_q;

  logic                out_valid_q;
  logic [ADDR_LEN-1:0] out_rd_q;
  logic                out_rdwen_q;
  logic [DATA_LEN-1:0] out_wb_q;

  logic busy, fire, is_mem, mis, ack;
  logic [1:0] a;

  assign busy     = (state_q == BUSY);
  assign in_ready = (state_q == IDLE);
  assign fire     = in_valid && in_ready;
  assign is_mem   = in_mem_ren || in_mem_wen;
  assign ack      = busy && dmem_ack;
  assign a        = addr_q[1:0];

`ifdef MISALIGN_TRAP_EN
  assign mis = is_mem &&
    (((in_funct3[1:0] == 2'b01) && in_alu_out[0]) ||
     ((in_funct3[1:0] == 2'b10) && (in_alu_out[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (fire && is_mem && !mis) state_d = BUSY;
    else if (ack)               state_d = IDLE;
  end

  // Store lanes derive from the latched address so they stay stable all of BUSY.
  logic [3:0]          be;
  logic [DATA_LEN-1:0] wd;
  always_comb begin
    be = 4'hF;
    wd = sdata_q;
    if (we_q) begin
      unique case (f3_q[1:0])
        2'b00: begin
          be = 4'b0001 << a;
          wd = {4{sdata_q[7:0]}};
        end
        2'b01: begin
          be = a[1] ? 4'b1100 : 4'b0011;
          wd = {2{sdata_q[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign dmem_req   = busy;
  assign dmem_we    = busy && we_q;
  assign dmem_addr  = busy ? {addr_q[DATA_LEN-1:2], 2'b00} : '0;
  assign dmem_be    = busy ? be : 4'h0;
  assign dmem_wdata = busy ? wd : '0;

  logic [DATA_LEN-1:0] sh_b, sh_h, ld;
  assign sh_b = dmem_rdata >> {a, 3'b000};
  assign sh_h = dmem_rdata >> {a[1], 4'b0000};

  always_comb begin
    unique case (f3_q)
      3'b000:  ld = {{(DATA_LEN-8){sh_b[7]}}, sh_b[7:0]};
      3'b100:  ld = {{(DATA_LEN-8){1'b0}}, sh_b[7:0]};
      3'b001:  ld = {{(DATA_LEN-16){sh_h[15]}}, sh_h[15:0]};
      3'b101:  ld = {{(DATA_LEN-16){1'b0}}, sh_h[15:0]};
      default: ld = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      rdwen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire && is_mem && !mis) begin
        addr_q  <= in_alu_out;
        sdata_q <= in_rs2_data;
        f3_q    <= in_funct3;
        we_q    <= in_mem_wen;
        rd_q    <= in_rd_addr;
        rdwen_q <= in_rd_wen && !in_mem_wen;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_rdwen_q <= 1'b0;
      out_wb_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (fire && !is_mem) begin
        out_valid_q <= 1'b1;
        out_rd_q    <= in_rd_addr;
        out_rdwen_q <= in_rd_wen;
        out_wb_q    <= in_alu_out;
      end else if (fire && mis) begin
        out_valid_q <= 1'b1;
        out_rd_q    <= in_rd_addr;
        out_rdwen_q <= 1'b0;
      end else if (ack) begin
        out_valid_q <= 1'b1;
        out_rd_q    <= rd_q;
        out_rdwen_q <= rdwen_q;
        if (!we_q) out_wb_q <= ld;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic                exc_q;
  logic [DATA_LEN-1:0] exc_addr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else if ((fire && (!is_mem || mis)) || ack) begin
      exc_q      <= fire && mis;
      exc_addr_q <= (fire && mis) ? in_alu_out : '0;
    end
  end
  assign out_exc      = exc_q;
  assign out_exc_addr = exc_addr_q;
`else
  assign out_exc      = 1'b0;
  assign out_exc_addr = '0;
`endif

  assign out_valid   = out_valid_q;
  assign out_rd_addr = out_rd_q;
  assign out_rd_wen  = out_rdwen_q;
  assign out_wb_data = out_wb_q;

endmodule
